seq_detect_param: RTL and testbench

//  Parametrised Moore serial-pattern detector; successor to the fixed 4-bit detector.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_det_window.sv | 46 ++++
 rtl/seq_detect_param.sv | 170 +++++++++++++++++
 tb/tb_seq_detect_param.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector:
// FSM state encodings, default reset pattern/length and the length-field width helper.
package seq_det_pkg;

    // FSM state encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_MATCH = 2'd2;

    // Shared defaults: 4-bit pattern 1010, first received bit is the MSB
    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_RST_PAT = 4'b1010;
    localparam int         DEF_RST_LEN = 4;

    // Width of a field able to hold any length 0..pat_w
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register plus length-masked comparator for seq_detect_param.
// hit is combinational: it reports whether the window formed by the stored history
// and the bit currently presented on bit_in equals the low len bits of pat.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    // Only PAT_W-1 past bits are kept: the longest window is those bits plus
    // the bit being sampled now, so an older bit could never take part in a compare.
    logic [PAT_W-2:0] hist_r;
    logic [PAT_W-1:0] window_s;
    logic [PAT_W-1:0] mask_s;

    // Candidate window and the mask selecting its low len bits
    always_comb begin
        window_s = {hist_r, bit_in};
        mask_s   = ~({PAT_W{1'b1}} << len);
        hit      = ((window_s & mask_s) == (pat & mask_s));
    end

    // Shift in accepted bits; a legal reconfiguration empties the history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= '0;
        end else if (clr) begin
            hist_r <= '0;
        end else if (shift_en) begin
            hist_r <= window_s[PAT_W-2:0];
        end else begin
            hist_r <= hist_r;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector.
// Pattern, length (2..PAT_W) and overlap mode are programmable at run time via cfg_we.
// out is a registered one-cycle flag per match, asserted the cycle after the last
// pattern bit is sampled. Optional feature: define SEQ_DET_COUNT_EN to add the
// saturating match_cnt output (width CNT_W).
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    parameter int               RST_LEN = DEF_RST_LEN
`ifdef SEQ_DET_COUNT_EN
    ,
    parameter int               CNT_W   = 8
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in,
    input  logic                         cfg_we,
    input  logic [PAT_W-1:0]             cfg_pat,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_ovl,
    output logic                         cfg_err,
`ifdef SEQ_DET_COUNT_EN
    output logic                         out,
    output logic [CNT_W-1:0]             match_cnt
`else
    output logic                         out
`endif
);

    localparam int               LEN_W   = len_w(PAT_W);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;
    logic [LEN_W-1:0] fill_r;
    logic [LEN_W-1:0] fill_n_s;
    logic [LEN_W-1:0] fill_inc_s;
    logic [1:0]       state_r;
    logic [1:0]       state_n_s;
    logic             out_r;
    logic             cfg_err_r;
    logic             cfg_legal_s;
    logic             cfg_ok_s;
    logic             take_s;
    logic             hit_s;

    // Config qualification; a bit arriving with a legal reconfiguration is dropped
    always_comb begin
        cfg_legal_s = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
        cfg_ok_s    = cfg_we && cfg_legal_s;
        take_s      = in_valid && !cfg_ok_s;
        fill_inc_s  = fill_r + LEN_W'(1);
    end

    seq_det_window #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clr      (cfg_ok_s),
        .shift_en (take_s),
        .bit_in   (in),
        .pat      (pat_r),
        .len      (len_r),
        .hit      (hit_s)
    );

    // Next-state and fill-count logic
    always_comb begin
        state_n_s = state_r;
        fill_n_s  = fill_r;
        if (cfg_ok_s) begin
            state_n_s = S_FILL;
            fill_n_s  = '0;
        end else begin
            case (state_r)
                S_FILL: begin
                    if (take_s) begin
                        if (fill_inc_s >= len_r) begin
                            // This bit completes the first full window, so it is compared
                            fill_n_s  = len_r;
                            state_n_s = hit_s ? S_MATCH : S_RUN;
                        end else begin
                            fill_n_s  = fill_inc_s;
                            state_n_s = S_FILL;
                        end
                    end else begin
                        fill_n_s  = fill_r;
                        state_n_s = S_FILL;
                    end
                end
                S_RUN: begin
                    fill_n_s  = fill_r;
                    state_n_s = (take_s && hit_s) ? S_MATCH : S_RUN;
                end
                S_MATCH: begin
                    if (ovl_r) begin
                        fill_n_s  = fill_r;
                        state_n_s = (take_s && hit_s) ? S_MATCH : S_RUN;
                    end else begin
                        // Non-overlapping: only bits after the match may form the next window
                        fill_n_s  = take_s ? LEN_W'(1) : LEN_W'(0);
                        state_n_s = S_FILL;
                    end
                end
                default: begin
                    fill_n_s  = '0;
                    state_n_s = S_FILL;
                end
            endcase
        end
    end

    // Configuration, FSM and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r     <= RST_PAT;
            len_r     <= LEN_W'(RST_LEN);
            ovl_r     <= 1'b1;
            fill_r    <= '0;
            state_r   <= S_FILL;
            out_r     <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            if (cfg_ok_s) begin
                pat_r <= cfg_pat;
                len_r <= cfg_len;
                ovl_r <= cfg_ovl;
            end else begin
                pat_r <= pat_r;
                len_r <= len_r;
                ovl_r <= ovl_r;
            end
            fill_r    <= fill_n_s;
            state_r   <= state_n_s;
            out_r     <= (state_n_s == S_MATCH);
            cfg_err_r <= cfg_we && !cfg_legal_s;
        end
    end

    assign out     = out_r;
    assign cfg_err = cfg_err_r;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Saturating count of out pulses; cleared by a legal reconfiguration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (cfg_ok_s) begin
            cnt_r <= '0;
        end else if ((state_n_s == S_MATCH) && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign match_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (PAT_W=4, default reset pattern 1010).
// With SEQ_DET_COUNT_EN defined the DUT is built with CNT_W=2 and match_cnt is checked too.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in;
    logic       cfg_we;
    logic [3:0] cfg_pat;
    logic [2:0] cfg_len;
    logic       cfg_ovl;
    logic       cfg_err;
    logic       out;
`ifdef SEQ_DET_COUNT_EN
    logic [1:0] match_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    seq_detect_param #(
        .PAT_W (4)
`ifdef SEQ_DET_COUNT_EN
        ,
        .CNT_W (2)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in       (in),
        .cfg_we   (cfg_we),
        .cfg_pat  (cfg_pat),
        .cfg_len  (cfg_len),
        .cfg_ovl  (cfg_ovl),
        .cfg_err  (cfg_err),
        .out      (out)
`ifdef SEQ_DET_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply n bits (MSB first), one per cycle, checking out after each edge
    task automatic run_seq(input logic [15:0] bits, input logic [15:0] vld,
                           input logic [15:0] exp, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            in_valid = vld[i];
            in       = bits[i];
            @(posedge clk);
            #1;
            check_eq($sformatf("%s_bit%0d", tag, n - 1 - i), {31'd0, out}, {31'd0, exp[i]});
        end
        in_valid = 1'b0;
        in       = 1'b0;
    endtask

    // One-cycle configuration write, optionally with a concurrent valid bit
    task automatic do_cfg(input logic [3:0] p, input logic [2:0] l, input logic o,
                          input logic v, input logic b, input logic exp_err, input string tag);
        cfg_we   = 1'b1;
        cfg_pat  = p;
        cfg_len  = l;
        cfg_ovl  = o;
        in_valid = v;
        in       = b;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        in       = 1'b0;
        check_eq({tag, "_err"}, {31'd0, cfg_err}, {31'd0, exp_err});
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in       = 1'b0;
        cfg_we   = 1'b0;
        cfg_pat  = 4'd0;
        cfg_len  = 3'd0;
        cfg_ovl  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out", {31'd0, out}, 32'd0);
        check_eq("rst_err", {31'd0, cfg_err}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
        check_eq("rst_cnt", {30'd0, match_cnt}, 32'd0);
`endif
        rst = 1'b0;

        // Defaults (1010, overlapping): matches after bits 4 and 6, then a stall
        run_seq(16'b1010100, 16'b1111110, 16'b0001010, 7, "def");

        // Non-overlapping 1010: single pulse
        do_cfg(4'b1010, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, "cfg_novl");
        check_eq("cfg_novl_out", {31'd0, out}, 32'd0);
        run_seq(16'b101010, 16'b111111, 16'b000100, 6, "novl");

        // len 3, pattern 111 (bit 3 ignored), overlapping, with in_valid gaps
        do_cfg(4'b1111, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_l3");
        run_seq(16'b111010010, 16'b111010011, 16'b001010010, 9, "l3");

        // Legal cfg discards the concurrent bit: 1 then 0,1,0 must not match
        do_cfg(4'b1010, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, "cfg_drop");
        run_seq(16'b01010, 16'b11111, 16'b00001, 5, "drop");

        // Illegal lengths: error pulse for one cycle, config unchanged
        do_cfg(4'b0110, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, "bad0");
        check_eq("bad0_out", {31'd0, out}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("bad0_pulse", {31'd0, cfg_err}, 32'd0);
        do_cfg(4'b1010, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_clr");
        do_cfg(4'b0110, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, "bad5");
        check_eq("bad5_out", {31'd0, out}, 32'd0);
        run_seq(16'b010, 16'b111, 16'b001, 3, "bad5_keep");

        // Mid-stream reset restores 1010/overlap and empties the history
        do_cfg(4'b0011, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, "cfg_pre_rst");
        run_seq(16'b101, 16'b111, 16'b000, 3, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_out", {31'd0, out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_seq(16'b0101010, 16'b1111111, 16'b0000101, 7, "post_rst");

`ifdef SEQ_DET_COUNT_EN
        // Counter saturation with CNT_W=2, then cleared by a legal cfg
        begin
            logic [5:0]  exp_out;
            logic [11:0] exp_cnt;
            exp_out = 6'b011111;
            exp_cnt = {2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            do_cfg(4'b0011, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_cnt");
            check_eq("cnt_clr0", {30'd0, match_cnt}, 32'd0);
            for (int i = 0; i < 6; i++) begin
                in_valid = 1'b1;
                in       = 1'b1;
                @(posedge clk);
                #1;
                check_eq($sformatf("cnt_out%0d", i), {31'd0, out}, {31'd0, exp_out[5-i]});
                check_eq($sformatf("cnt_val%0d", i), {30'd0, match_cnt},
                         {30'd0, exp_cnt[(5-i)*2 +: 2]});
            end
            in_valid = 1'b0;
            do_cfg(4'b1010, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_cnt2");
            check_eq("cnt_clr1", {30'd0, match_cnt}, 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
